gate_response_checker: RTL and testbench

GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

---
 rtl/gate_response_checker.sv | 119 +++++++++++
 tb/tb_gate_response_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
//------------------------------------------------------------------------------
// gate_response_checker: scores observed 2-input gate responses against the
// truth table of a latched op (AND/OR/XOR/NAND) and tracks row coverage.
// Optional feature macro: GATE_CHK_LAST_FAIL_EN (adds last_fail = {a,b,y}).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gate_response_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       cov,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef GATE_CHK_LAST_FAIL_EN
  ,
  output logic [2:0]       last_fail
`endif
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_op;

  logic       w_expected;
  logic       w_match;
  logic [3:0] w_row_bit;
  logic [3:0] w_cov_next;
  logic       w_accept;

  always_comb begin
    w_expected = 1'b0;
    unique case (r_op)
      OP_AND:  w_expected = a & b;
      OP_OR:   w_expected = a | b;
      OP_XOR:  w_expected = a ^ b;
      OP_NAND: w_expected = ~(a & b);
      default: w_expected = 1'b0;
    endcase
  end

  assign w_match    = (w_expected == y);
  assign w_row_bit  = 4'b0001 << {a, b};
  assign w_cov_next = cov | w_row_bit;
  // start outranks a same-cycle sample, so only a quiet-start cycle is scored
  assign w_accept   = (r_state == ST_RUN) && vld && !start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_AND;
      pass_cnt <= '0;
      fail_cnt <= '0;
      cov      <= 4'b0000;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (start) begin
      r_state  <= ST_RUN;
      r_op     <= op;
      pass_cnt <= '0;
      fail_cnt <= '0;
      cov      <= 4'b0000;
      busy     <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (w_accept) begin
      if (w_match) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
        err <= 1'b1;
      end
      cov <= w_cov_next;
      // completion is decided purely by coverage, on the same edge as the last count
      if (w_cov_next == 4'b1111) begin
        r_state <= ST_DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

`ifdef GATE_CHK_LAST_FAIL_EN
  always_ff @(posedge clk) begin
    if (rst || start) begin
      last_fail <= 3'b000;
    end else if (w_accept && !w_match) begin
      last_fail <= {a, b, y};
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_gate_response_checker.sv
//------------------------------------------------------------------------------
// tb_gate_response_checker: directed steps against a reference model whose
// expected outputs travel through a scoreboard queue; CNT_W=8 and CNT_W=2 DUTs.
//------------------------------------------------------------------------------
`default_nettype none

module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic       vld = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       y = 1'b0;

  logic [7:0] pass_cnt, fail_cnt;
  logic [1:0] pass_cnt2, fail_cnt2;
  logic [3:0] cov, cov2;
  logic       busy, done, err, busy2, done2, err2;
`ifdef GATE_CHK_LAST_FAIL_EN
  logic [2:0] last_fail, last_fail2;
`endif

  always #5 clk = ~clk;

  gate_response_checker #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .vld(vld),
    .a(a), .b(b), .y(y),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .cov(cov),
    .busy(busy), .done(done), .err(err)
`ifdef GATE_CHK_LAST_FAIL_EN
    , .last_fail(last_fail)
`endif
  );

  gate_response_checker #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .vld(vld),
    .a(a), .b(b), .y(y),
    .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .cov(cov2),
    .busy(busy2), .done(done2), .err(err2)
`ifdef GATE_CHK_LAST_FAIL_EN
    , .last_fail(last_fail2)
`endif
  );

  typedef struct {
    string       tag;
    logic [31:0] pass;
    logic [31:0] fail;
    logic [3:0]  cov;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] pass2;
    logic [31:0] fail2;
    logic [2:0]  lf;
  } exp_t;

  exp_t q[$];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  int         m_st = 0;  // 0 idle, 1 run, 2 done
  logic [1:0] m_op = 2'b00;
  int         m_pass = 0, m_fail = 0, m_pass2 = 0, m_fail2 = 0;
  logic [3:0] m_cov = 4'b0000;
  logic       m_err = 1'b0;
  logic [2:0] m_lf = 3'b000;
  // Truth tables indexed by {a,b}: AND, OR, XOR, NAND
  logic [3:0] tt [4] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model(input logic s_rst, s_start, input logic [1:0] s_op,
                       input logic s_vld, s_a, s_b, s_y);
    logic [3:0] row;
    logic       e;
    if (s_rst) begin
      m_st = 0; m_op = 2'b00; m_pass = 0; m_fail = 0; m_pass2 = 0; m_fail2 = 0;
      m_cov = 4'b0000; m_err = 1'b0; m_lf = 3'b000;
    end else if (s_start) begin
      m_st = 1; m_op = s_op; m_pass = 0; m_fail = 0; m_pass2 = 0; m_fail2 = 0;
      m_cov = 4'b0000; m_err = 1'b0; m_lf = 3'b000;
    end else if (m_st == 1 && s_vld) begin
      row = tt[m_op];
      e = row[{s_a, s_b}];
      if (e == s_y) begin
        if (m_pass < 255) m_pass++;
        if (m_pass2 < 3) m_pass2++;
      end else begin
        if (m_fail < 255) m_fail++;
        if (m_fail2 < 3) m_fail2++;
        m_err = 1'b1;
        m_lf = {s_a, s_b, s_y};
      end
      m_cov[{s_a, s_b}] = 1'b1;
      if (m_cov == 4'b1111) m_st = 2;
    end
  endtask

  task automatic step(input string tag, input logic s_rst, s_start, input logic [1:0] s_op,
                      input logic s_vld, s_a, s_b, s_y);
    exp_t e, got;
    @(negedge clk);
    rst = s_rst; start = s_start; op = s_op; vld = s_vld; a = s_a; b = s_b; y = s_y;
    model(s_rst, s_start, s_op, s_vld, s_a, s_b, s_y);
    e.tag = tag; e.pass = 32'(m_pass); e.fail = 32'(m_fail); e.cov = m_cov;
    e.busy = (m_st == 1); e.done = (m_st == 2); e.err = m_err;
    e.pass2 = 32'(m_pass2); e.fail2 = 32'(m_fail2); e.lf = m_lf;
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    check({got.tag, ".pass"}, 32'(pass_cnt), got.pass);
    check({got.tag, ".fail"}, 32'(fail_cnt), got.fail);
    check({got.tag, ".cov"},  32'(cov),      32'(got.cov));
    check({got.tag, ".busy"}, 32'(busy),     32'(got.busy));
    check({got.tag, ".done"}, 32'(done),     32'(got.done));
    check({got.tag, ".err"},  32'(err),      32'(got.err));
    check({got.tag, ".pass2"}, 32'(pass_cnt2), got.pass2);
    check({got.tag, ".fail2"}, 32'(fail_cnt2), got.fail2);
`ifdef GATE_CHK_LAST_FAIL_EN
    check({got.tag, ".last_fail"}, 32'(last_fail), 32'(got.lf));
`endif
  endtask

  initial begin
    step("rst0", 1, 0, 2'b00, 0, 0, 0, 0);
    step("rst1", 1, 1, 2'b10, 1, 1, 1, 0);

    // AND: all four rows correct
    step("and_start", 0, 1, 2'b00, 0, 0, 0, 0);
    step("and_00",    0, 0, 2'b00, 1, 0, 0, 0);
    step("and_01",    0, 0, 2'b00, 1, 0, 1, 0);
    step("and_10",    0, 0, 2'b00, 1, 1, 0, 0);
    step("and_11",    0, 0, 2'b00, 1, 1, 1, 1);
    step("done_hold", 0, 0, 2'b00, 1, 1, 1, 0);
    check("and_final_pass", 32'(pass_cnt), 32'd4);
    check("and_final_done", 32'(done), 32'd1);

    // XOR with one wrong response on row 11
    step("xor_start", 0, 1, 2'b10, 0, 0, 0, 0);
    step("xor_00",    0, 0, 2'b10, 1, 0, 0, 0);
    step("xor_01",    0, 0, 2'b10, 1, 0, 1, 1);
    step("xor_10",    0, 0, 2'b10, 1, 1, 0, 1);
    step("xor_11",    0, 0, 2'b10, 1, 1, 1, 1);
    check("xor_final_fail", 32'(fail_cnt), 32'd1);
    check("xor_final_err",  32'(err), 32'd1);

    // OR with repeated rows; run stays open; op change mid-run ignored
    step("or_start", 0, 1, 2'b01, 0, 0, 0, 0);
    step("or_00a",   0, 0, 2'b01, 1, 0, 0, 0);
    step("or_00b",   0, 0, 2'b01, 1, 0, 0, 0);
    step("or_00c",   0, 0, 2'b01, 1, 0, 0, 0);
    step("or_11",    0, 0, 2'b11, 1, 1, 1, 1);
    step("or_idle",  0, 0, 2'b01, 0, 1, 0, 0);
    check("or_final_cov", 32'(cov), 32'h9);

    // start and vld together: restart wins, sample discarded
    step("restart_vld", 0, 1, 2'b01, 1, 1, 0, 1);
    step("restart_01",  0, 0, 2'b00, 1, 0, 1, 1);

    // rst mid-run, then vld with no start
    step("mid_start", 0, 1, 2'b00, 0, 0, 0, 0);
    step("mid_s1",    0, 0, 2'b00, 1, 0, 0, 0);
    step("mid_s2",    0, 0, 2'b00, 1, 1, 1, 0);
    step("mid_rst",   1, 0, 2'b00, 1, 1, 0, 0);
    step("idle_vld",  0, 0, 2'b00, 1, 1, 1, 1);

    // NAND, five passes: 2-bit counter saturates
    step("nand_start", 0, 1, 2'b11, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("nand_00", 0, 0, 2'b11, 1, 0, 0, 1);
    check("sat_pass2", 32'(pass_cnt2), 32'd3);
    check("sat_pass8", 32'(pass_cnt), 32'd5);
    step("nand_10bad", 0, 0, 2'b11, 1, 1, 0, 0);

    @(negedge clk);
    vld = 1'b0; start = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
